// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared op codes, iterative-unit FSM state type and op classification
// Contents: op_e (operation codes), md_state_e (multiply/divide FSM states),
//           is_multicycle() (true for ops served by the iterative unit).
package ex_pkg;

    localparam int OP_BITS = 5;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_NOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_LUI   = 5'd11,
        OP_MUL   = 5'd16,
        OP_MULH  = 5'd17,
        OP_MULHU = 5'd18,
        OP_DIV   = 5'd20,
        OP_DIVU  = 5'd21,
        OP_REM   = 5'd22,
        OP_REMU  = 5'd23
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_multicycle(input op_e op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative radix-2 multiply / restoring divide unit
// Ports: clk, rst_n (async active-low); kill (sync abort to IDLE);
//        start/op/a/b (load operands, IDLE only); take (result consumed in DONE);
//        busy (not IDLE); done (in DONE, result valid); result (sign-fixed result).
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            start,
    input  op_e             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            take,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    op_e              op_q, op_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;

    logic            in_div, in_signed;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            q_div;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_neg;

    // Operands are reduced to magnitudes up front; signs are reapplied in DONE.
    always_comb begin
        in_div    = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        in_signed = op inside {OP_MULH, OP_DIV, OP_REM};
        a_mag     = (in_signed && a[XLEN-1]) ? -a : a;
        b_mag     = (in_signed && b[XLEN-1]) ? -b : b;
    end

    // {acc, lo} is the shared double-width working register: product for
    // multiply (multiplier shifted out of lo), remainder:quotient for divide.
    always_comb begin
        q_div     = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    op_d    = op;
                    neg_a_d = in_signed && a[XLEN-1];
                    neg_b_d = in_signed && b[XLEN-1];
                    lo_d    = in_div ? a_mag : b_mag;
                    opnd_d  = in_div ? b_mag : a_mag;
                end
            end
            ST_RUN: begin
                if (q_div) begin
                    // Borrow out of the trial subtract means the divisor did not fit.
                    if (!div_diff[XLEN]) begin
                        acc_d = div_diff[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[XLEN:1];
                    lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (take) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Unsigned restoring division by zero already yields all-ones / dividend;
    // only signed DIV needs an override so the quotient sign fix-up is skipped.
    // MIN / -1 falls out of the magnitude path as MIN with remainder 0.
    always_comb begin
        prod_neg = -{acc_q, lo_q};
        case (op_q)
            OP_MUL:   result = lo_q;
            OP_MULH:  result = (neg_a_q ^ neg_b_q) ? prod_neg[2*XLEN-1:XLEN] : acc_q;
            OP_MULHU: result = acc_q;
            OP_DIV:   result = (opnd_q == '0) ? '1 :
                               ((neg_a_q ^ neg_b_q) ? -lo_q : lo_q);
            OP_DIVU:  result = lo_q;
            OP_REM:   result = neg_a_q ? -acc_q : acc_q;
            OP_REMU:  result = acc_q;
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            op_q    <= OP_ADD;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: rtl/stage_ex_pipe.sv
// rtl/stage_ex_pipe.sv - execute stage: single-cycle ALU plus iterative mul/div, registered EX/MEM slot
// Ports: clk, rst_n (async active-low), flush (sync kill);
//        id_valid/id_ready/id_op/id_a/id_b/id_rd/id_wen (operation from ID);
//        mem_valid/mem_ready/mem_result/mem_rd/mem_wen (EX/MEM slot toward MEM);
//        busy (multiply/divide in progress).
module stage_ex_pipe
    import ex_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [OP_W-1:0]       id_op,
    input  logic [XLEN-1:0]       id_a,
    input  logic [XLEN-1:0]       id_b,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wen,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [XLEN-1:0]       mem_result,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_wen,
    output logic                  busy
);

    localparam int SHW = $clog2(XLEN);

    op_e             op_in;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_known;
    logic            mc_op, slot_free, accept, md_start, md_take;
    logic            md_busy, md_done;
    logic [XLEN-1:0] md_result;

    logic                  mem_valid_q, mem_valid_d;
    logic [XLEN-1:0]       mem_result_q, mem_result_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
    logic                  pend_wen_q, pend_wen_d;

    assign op_in = op_e'(OP_BITS'(id_op));

    always_comb begin
        shamt     = id_b[SHW-1:0];
        alu_known = 1'b1;
        alu_res   = '0;
        case (op_in)
            OP_ADD:  alu_res = id_a + id_b;
            OP_SUB:  alu_res = id_a - id_b;
            OP_AND:  alu_res = id_a & id_b;
            OP_OR:   alu_res = id_a | id_b;
            OP_XOR:  alu_res = id_a ^ id_b;
            OP_NOR:  alu_res = ~(id_a | id_b);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(id_a) < $signed(id_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, id_a < id_b};
            OP_SLL:  alu_res = id_a << shamt;
            OP_SRL:  alu_res = id_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(id_a) >>> shamt);
            OP_LUI:  alu_res = {id_b[XLEN/2-1:0], {(XLEN/2){1'b0}}};
            default: alu_known = 1'b0;
        endcase
    end

    // The slot can take new data when empty or when MEM drains it this cycle.
    assign slot_free = !mem_valid_q || mem_ready;
    assign id_ready  = !md_busy && !flush && slot_free;
    assign accept    = id_valid && id_ready;
    assign mc_op     = is_multicycle(op_in);
    assign md_start  = accept && mc_op;
    assign md_take   = md_done && slot_free && !flush;

    ex_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .kill   (flush),
        .start  (md_start),
        .op     (op_in),
        .a      (id_a),
        .b      (id_b),
        .take   (md_take),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        mem_valid_d  = mem_valid_q;
        mem_result_d = mem_result_q;
        mem_rd_d     = mem_rd_q;
        mem_wen_d    = mem_wen_q;
        pend_rd_d    = pend_rd_q;
        pend_wen_d   = pend_wen_q;
        if (md_start) begin
            pend_rd_d  = id_rd;
            pend_wen_d = id_wen;
        end
        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (md_take) begin
            mem_valid_d  = 1'b1;
            mem_result_d = md_result;
            mem_rd_d     = pend_rd_q;
            mem_wen_d    = pend_wen_q;
        end else if (accept && !mc_op) begin
            mem_valid_d  = 1'b1;
            mem_result_d = alu_res;
            mem_rd_d     = id_rd;
            mem_wen_d    = id_wen && alu_known;
        end else if (mem_valid_q && mem_ready) begin
            mem_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q  <= 1'b0;
            mem_result_q <= '0;
            mem_rd_q     <= '0;
            mem_wen_q    <= 1'b0;
            pend_rd_q    <= '0;
            pend_wen_q   <= 1'b0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            mem_result_q <= mem_result_d;
            mem_rd_q     <= mem_rd_d;
            mem_wen_q    <= mem_wen_d;
            pend_rd_q    <= pend_rd_d;
            pend_wen_q   <= pend_wen_d;
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_result = mem_result_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wen    = mem_wen_q;
    assign busy       = md_busy;

endmodule
